// File: rtl/q_event_fifo.sv
// q_event_fifo: timestamps qualified charge words and buffers them in a
// first-word-fall-through FIFO drained over a valid/ready handshake.
// Events below q_min are ignored; events arriving while full are dropped
// and counted in a saturating overflow counter.
module q_event_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_WIDTH   = 32,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [30:0]           q_in,
    input  logic                  q_valid_in,
    input  logic [30:0]           q_min,
    input  logic                  evt_ready,
    input  logic                  clr_ovf,
    output logic                  evt_valid,
    output logic [30:0]           evt_q,
    output logic [TS_WIDTH-1:0]   evt_ts,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic [OVF_WIDTH-1:0]  ovf_cnt,
    output logic                  full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [TS_WIDTH-1:0]   TS_ONE   = 1;
    localparam logic [OVF_WIDTH-1:0]  OVF_ONE  = 1;

    logic [TS_WIDTH-1:0]   ts;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic [30:0]           mem_q  [DEPTH];
    logic [TS_WIDTH-1:0]   mem_ts [DEPTH];
    logic                  cand, wr_en, drop, pop;
    logic [30:0]           head_q_nxt;
    logic [TS_WIDTH-1:0]   head_ts_nxt;

    // Qualification and write/drop decisions use only the registered full flag,
    // so a pop in the same cycle never rescues an incoming event.
    assign cand  = q_valid_in && ($signed(q_in) >= $signed(q_min));
    assign wr_en = cand && !full;
    assign drop  = cand && full;
    assign pop   = evt_valid && evt_ready;
    assign rd_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;

    // Next occupancy and next head word. The head bypasses storage when the
    // entry being written this cycle is the one that becomes the head.
    always_comb begin
        count_nxt   = fifo_count;
        head_q_nxt  = '0;
        head_ts_nxt = '0;
        case ({wr_en, pop})
            2'b10:   count_nxt = fifo_count + CNT_ONE;
            2'b01:   count_nxt = fifo_count - CNT_ONE;
            default: count_nxt = fifo_count;
        endcase
        if (count_nxt != '0) begin
            if (wr_en && (wr_ptr == rd_nxt)) begin
                head_q_nxt  = q_in;
                head_ts_nxt = ts;
            end else begin
                head_q_nxt  = mem_q[rd_nxt];
                head_ts_nxt = mem_ts[rd_nxt];
            end
        end
    end

    // Event storage; contents are don't-care out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr]  <= q_in;
            mem_ts[wr_ptr] <= ts;
        end
    end

    // Timestamp, pointers, occupancy and registered head/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            evt_valid  <= 1'b0;
            full       <= 1'b0;
            evt_q      <= '0;
            evt_ts     <= '0;
        end else begin
            ts         <= ts + TS_ONE;
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr     <= rd_nxt;
            fifo_count <= count_nxt;
            evt_valid  <= (count_nxt != '0);
            full       <= (count_nxt == CNT_FULL);
            evt_q      <= head_q_nxt;
            evt_ts     <= head_ts_nxt;
        end
    end

    // Saturating dropped-event counter; a clear in a drop cycle leaves one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt <= '0;
        end else if (clr_ovf) begin
            ovf_cnt <= drop ? OVF_ONE : '0;
        end else if (drop && !(&ovf_cnt)) begin
            ovf_cnt <= ovf_cnt + OVF_ONE;
        end
    end
endmodule

// File: tb/tb_q_event_fifo.sv
// Directed bench for q_event_fifo: a vector table for qualification and
// handshake behaviour, plus hand sequences for fill/overflow, wrap and reset.
module tb_q_event_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [30:0] q_in = '0;
    logic        q_valid_in = 1'b0;
    logic [30:0] q_min = '0;
    logic        evt_ready = 1'b0;
    logic        clr_ovf = 1'b0;

    logic        evt_valid, full, evt_valid4, full4;
    logic [30:0] evt_q, evt_q4;
    logic [31:0] evt_ts;
    logic [3:0]  evt_ts4;
    logic [4:0]  fifo_count, fifo_count4;
    logic [15:0] ovf_cnt, ovf_cnt4;

    logic [31:0] tb_ts;
    logic [31:0] cap;
    logic [31:0] ets [32];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    q_event_fifo dut (
        .clk(clk), .reset_n(reset_n), .q_in(q_in), .q_valid_in(q_valid_in),
        .q_min(q_min), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
        .evt_valid(evt_valid), .evt_q(evt_q), .evt_ts(evt_ts),
        .fifo_count(fifo_count), .ovf_cnt(ovf_cnt), .full(full)
    );

    q_event_fifo #(.TS_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .q_in(q_in), .q_valid_in(q_valid_in),
        .q_min(q_min), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
        .evt_valid(evt_valid4), .evt_q(evt_q4), .evt_ts(evt_ts4),
        .fifo_count(fifo_count4), .ovf_cnt(ovf_cnt4), .full(full4)
    );

    // Reference free-running timestamp
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_ts <= '0;
        else          tb_ts <= tb_ts + 32'd1;
    end

    typedef struct {
        logic        v;
        logic [30:0] q;
        logic [30:0] qmin;
        logic        rdy;
        logic        ev;
        logic [30:0] eq;
        int          ecnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 31'd49,    31'd50,    1'b0, 1'b0, 31'd0,   0};
        tbl[1]  = '{1'b1, 31'(-3),   31'd50,    1'b0, 1'b0, 31'd0,   0};
        tbl[2]  = '{1'b1, 31'd50,    31'd50,    1'b0, 1'b1, 31'd50,  1};
        tbl[3]  = '{1'b1, 31'(-5),   31'(-10),  1'b0, 1'b1, 31'd50,  2};
        tbl[4]  = '{1'b0, 31'd0,     31'(-10),  1'b1, 1'b1, 31'(-5), 1};
        tbl[5]  = '{1'b0, 31'd0,     31'(-10),  1'b1, 1'b0, 31'd0,   0};
        tbl[6]  = '{1'b0, 31'd0,     31'(-10),  1'b1, 1'b0, 31'd0,   0};
        tbl[7]  = '{1'b1, 31'(-11),  31'(-10),  1'b0, 1'b0, 31'd0,   0};
        tbl[8]  = '{1'b1, 31'd7,     31'(-10),  1'b1, 1'b1, 31'd7,   1};
        tbl[9]  = '{1'b1, 31'd8,     31'(-10),  1'b1, 1'b1, 31'd8,   1};
        tbl[10] = '{1'b0, 31'd0,     31'(-10),  1'b0, 1'b1, 31'd8,   1};
        tbl[11] = '{1'b0, 31'd0,     31'(-10),  1'b1, 1'b0, 31'd0,   0};

        // Reset state
        #22;
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf", 64'(ovf_cnt), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_q", 64'(evt_q), 64'd0);
        chk("rst_ts", 64'(evt_ts), 64'd0);
        step;
        reset_n = 1'b1;

        // 1: single event at ts=5, held while not ready
        for (int i = 0; i < 20 && tb_ts != 32'd5; i++) step;
        chk("t1_reach_ts5", 64'(tb_ts), 64'd5);
        q_min = 31'd0; q_in = 31'd100; q_valid_in = 1'b1;
        step;
        q_valid_in = 1'b0;
        chk("t1_valid", 64'(evt_valid), 64'd1);
        chk("t1_count", 64'(fifo_count), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t1_hold_q", 64'(evt_q), 64'd100);
            chk("t1_hold_ts", 64'(evt_ts), 64'd5);
            step;
        end
        evt_ready = 1'b1;
        step;
        evt_ready = 1'b0;
        chk("t1_drain", 64'(fifo_count), 64'd0);

        // 2: qualification and handshake table
        for (int i = 0; i < 12; i++) begin
            q_valid_in = tbl[i].v; q_in = tbl[i].q; q_min = tbl[i].qmin;
            evt_ready = tbl[i].rdy;
            step;
            chk($sformatf("tbl%0d_valid", i), 64'(evt_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), 64'(fifo_count), 64'(tbl[i].ecnt));
            if (tbl[i].ev)
                chk($sformatf("tbl%0d_q", i), 64'(evt_q), 64'(tbl[i].eq));
        end
        q_valid_in = 1'b0; evt_ready = 1'b0; q_min = 31'd0;

        // 3: 18 back-to-back candidates into a 16-deep FIFO
        for (int i = 1; i <= 18; i++) begin
            q_in = 31'(i); q_valid_in = 1'b1; ets[i] = tb_ts;
            step;
            if (i == 15) chk("t3_full_at15", 64'(full), 64'd0);
            if (i == 16) chk("t3_full_at16", 64'(full), 64'd1);
        end
        q_valid_in = 1'b0;
        chk("t3_count", 64'(fifo_count), 64'd16);
        chk("t3_ovf", 64'(ovf_cnt), 64'd2);
        chk("t3_head_q", 64'(evt_q), 64'd1);
        chk("t3_head_ts", 64'(evt_ts), 64'(ets[1]));

        // 4: candidate + pop while full is still dropped
        q_in = 31'd99; q_valid_in = 1'b1; evt_ready = 1'b1;
        step;
        q_valid_in = 1'b0; evt_ready = 1'b0;
        chk("t4_ovf", 64'(ovf_cnt), 64'd3);
        chk("t4_count", 64'(fifo_count), 64'd15);
        chk("t4_full", 64'(full), 64'd0);
        chk("t4_head", 64'(evt_q), 64'd2);
        q_in = 31'd17; q_valid_in = 1'b1; ets[17] = tb_ts;
        step;
        chk("t4_refull", 64'(full), 64'd1);
        q_in = 31'd55; clr_ovf = 1'b1;
        step;
        q_valid_in = 1'b0; clr_ovf = 1'b0;
        chk("t4_clr_drop", 64'(ovf_cnt), 64'd1);
        clr_ovf = 1'b1;
        step;
        clr_ovf = 1'b0;
        chk("t4_clr", 64'(ovf_cnt), 64'd0);
        evt_ready = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            chk($sformatf("t3_drain_q%0d", k), 64'(evt_q), 64'(k));
            chk($sformatf("t3_drain_ts%0d", k), 64'(evt_ts), 64'(ets[k]));
            step;
        end
        evt_ready = 1'b0;
        chk("t3_empty_valid", 64'(evt_valid), 64'd0);
        chk("t3_empty_count", 64'(fifo_count), 64'd0);

        // 5: streaming write+pop every cycle; 4-bit timestamp wraps
        evt_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            q_in = 31'(300 + k); q_valid_in = 1'b1; cap = tb_ts;
            step;
            chk($sformatf("t5_count%0d", k), 64'(fifo_count), 64'd1);
            chk($sformatf("t5_q%0d", k), 64'(evt_q), 64'(300 + k));
            chk($sformatf("t5_ts%0d", k), 64'(evt_ts), 64'(cap));
            chk($sformatf("t5_ts4_%0d", k), 64'(evt_ts4), 64'(cap[3:0]));
            chk($sformatf("t5_q4_%0d", k), 64'(evt_q4), 64'(300 + k));
        end
        q_valid_in = 1'b0;
        step;
        evt_ready = 1'b0;
        chk("t5_empty", 64'(fifo_count), 64'd0);

        // 6: asynchronous reset with entries queued
        for (int k = 0; k < 7; k++) begin
            q_in = 31'(k + 1); q_valid_in = 1'b1;
            step;
        end
        q_valid_in = 1'b0;
        chk("t6_count7", 64'(fifo_count), 64'd7);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(evt_valid), 64'd0);
        chk("t6_async_count", 64'(fifo_count), 64'd0);
        chk("t6_async_q", 64'(evt_q), 64'd0);
        chk("t6_async_ts", 64'(evt_ts), 64'd0);
        step;
        reset_n = 1'b1;
        step;
        chk("t6_post_valid", 64'(evt_valid), 64'd0);
        chk("t6_post_count", 64'(fifo_count), 64'd0);
        chk("t6_post_ovf", 64'(ovf_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
